// File: rtl/brr_filter_buffer_if.sv
// Bundles the sample handshake and the window port of the BRR filter/buffer.
//   master : the decoder side; drives restart, the input handshake and do_consume
//   slave  : brr_filter_buffer; drives in_ready, the count and the window
interface brr_filter_buffer_if #(
   parameter int PTR_W = 3
);
   logic                restart;
   logic                in_valid;
   logic                in_ready;
   logic signed [15:0]  in_sample;
   logic        [1:0]   in_filter;
   logic                do_consume;
   logic        [PTR_W:0] remaining_sample_count;
   logic                window_valid;
   logic signed [15:0]  sample_out_0;
   logic signed [15:0]  sample_out_1;
   logic signed [15:0]  sample_out_2;

   modport master (
      output restart, in_valid, in_sample, in_filter, do_consume,
      input  in_ready, remaining_sample_count, window_valid,
             sample_out_0, sample_out_1, sample_out_2
   );

   modport slave (
      input  restart, in_valid, in_sample, in_filter, do_consume,
      output in_ready, remaining_sample_count, window_valid,
             sample_out_0, sample_out_1, sample_out_2
   );
endinterface

// File: rtl/brr_filter_buffer.sv
// BRR prediction filter and circular sample buffer.
// Takes raw shifted BRR samples with their block filter mode, applies the
// ADPCM predictor from the last two outputs, clamps to 16 bits, wraps to
// 15 bits and stores the result. A three-sample window starting at the
// oldest unconsumed sample feeds the interpolation stage.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of brr_filter_buffer_if (restart, in_valid/in_ready,
//            in_sample, in_filter, do_consume, remaining_sample_count,
//            window_valid, sample_out_0..2)
module brr_filter_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input logic               clock,
   input logic               reset,
   brr_filter_buffer_if.slave bus
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic signed [15:0]       smp_q;
   logic        [1:0]        flt_q;
   logic signed [17:0]       sum_q, sum_d;
   logic signed [15:0]       p1_q, p2_q;
   logic        [PTR_W-1:0]  rd_q, wr_q;
   logic        [CNT_W-1:0]  cnt_q, cnt_d;
   logic signed [15:0]       mem_q [DEPTH];

   logic                     rdy;
   logic                     accept;
   logic                     wr_en;
   logic                     rd_en;
   logic signed [15:0]       out_w;
   logic signed [19:0]       smp_w, p1_w, p2_w;

   // Clamp to the 16-bit range, then keep only 15 bits sign-extended to 16.
   // Saturated extremes wrap as well: +32767 becomes -1, -32768 becomes 0.
   function automatic logic signed [15:0] sat_wrap(input logic signed [17:0] v);
      logic [14:0] c;
      if (v > 18'sd32767)
         c = 15'h7fff;
      else if (v < -18'sd32768)
         c = 15'h0000;
      else
         c = v[14:0];
      return {c[14], c};
   endfunction

   // Control: IDLE accepts, CALC forms the sum, WRITE stores it.
   always_comb begin
      state_d = state_q;
      rdy     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdy = (cnt_q < FULL_CNT);
            if (bus.in_valid && rdy)
               state_d = ST_CALC;
         end
         ST_CALC:  state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (bus.restart || reset) begin
         rdy     = 1'b0;
         state_d = ST_IDLE;
      end
   end

   assign accept = bus.in_valid && rdy;
   assign wr_en  = (state_q == ST_WRITE);
   assign rd_en  = bus.do_consume && (cnt_q != '0);

   // Predictor terms are evaluated at 20 bits so the -13*p1 product keeps its
   // low bits before the shift; the final sum always fits in 18 bits.
   always_comb begin
      smp_w = smp_q;
      p1_w  = p1_q;
      p2_w  = p2_q;
      sum_d = '0;
      case (flt_q)
         2'd0: sum_d = 18'(smp_w >>> 1);
         2'd1: sum_d = 18'((smp_w >>> 1) + p1_w + ((-p1_w) >>> 4));
         2'd2: sum_d = 18'((smp_w >>> 1) + (p1_w <<< 1)
                           + ((-(p1_w * 20'sd3)) >>> 5)
                           - p2_w + (p2_w >>> 4));
         default: sum_d = 18'((smp_w >>> 1) + (p1_w <<< 1)
                              + ((-(p1_w * 20'sd13)) >>> 6)
                              - p2_w + ((p2_w * 20'sd3) >>> 4));
      endcase
   end

   assign out_w = sat_wrap(sum_q);

   // A write and a consume in the same cycle cancel in the occupancy count.
   always_comb begin
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         smp_q   <= '0;
         flt_q   <= '0;
         sum_q   <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (bus.restart) begin
         // Key-on: drop any in-flight sample and forget all history.
         state_q <= ST_IDLE;
         smp_q   <= '0;
         flt_q   <= '0;
         sum_q   <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            smp_q <= bus.in_sample;
            flt_q <= bus.in_filter;
         end
         if (state_q == ST_CALC)
            sum_q <= sum_d;
         if (wr_en) begin
            mem_q[wr_q] <= out_w;
            wr_q        <= wr_q + PTR_W'(1);
            p2_q        <= p1_q;
            p1_q        <= out_w;
         end
         if (rd_en)
            rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   assign bus.in_ready               = rdy;
   assign bus.remaining_sample_count = cnt_q;
   assign bus.window_valid           = (cnt_q >= CNT_W'(3));
   assign bus.sample_out_0           = mem_q[rd_q];
   assign bus.sample_out_1           = mem_q[rd_q + PTR_W'(1)];
   assign bus.sample_out_2           = mem_q[rd_q + PTR_W'(2)];

endmodule

// File: tb/tb_brr_filter_buffer.sv
// Directed bench for brr_filter_buffer: filter modes, clamp/wrap, full and
// simultaneous write/consume, restart and asynchronous reset.
module tb_brr_filter_buffer;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   brr_filter_buffer_if #(.PTR_W(PTR_W)) bus ();

   brr_filter_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Offer one sample and return once it has been written to the buffer.
   task automatic push(input int smp, input int flt);
      int n;
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'(smp);
      bus.in_filter = 2'(flt);
      n = 0;
      while (!bus.in_ready && n < 16) begin
         @(negedge clock);
         n++;
      end
      chk("push_ready", int'(bus.in_ready), 1);
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_restart();
      @(negedge clock);
      bus.restart = 1'b1;
      @(negedge clock);
      bus.restart = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.restart    = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_sample  = '0;
      bus.in_filter  = '0;
      bus.do_consume = 1'b0;

      // Reset state
      #2 reset = 1'b1;
      @(negedge clock);
      chk("rst_count", int'(bus.remaining_sample_count), 0);
      chk("rst_wvalid", int'(bus.window_valid), 0);
      chk("rst_ready", int'(bus.in_ready), 0);
      chk("rst_out0", bus.sample_out_0, 0);
      chk("rst_out2", bus.sample_out_2, 0);
      @(negedge clock);
      reset = 1'b0;
      #1 chk("post_rst_ready", int'(bus.in_ready), 1);

      // Filter 0 and handshake-to-count latency
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sh1000;
      bus.in_filter = 2'd0;
      @(posedge clock);
      @(negedge clock);
      bus.in_valid  = 1'b0;
      bus.in_sample = -16'sd1;
      bus.in_filter = 2'd3;
      chk("f0_calc_count", int'(bus.remaining_sample_count), 0);
      chk("f0_calc_ready", int'(bus.in_ready), 0);
      @(negedge clock);
      chk("f0_write_count", int'(bus.remaining_sample_count), 0);
      chk("f0_write_ready", int'(bus.in_ready), 0);
      @(negedge clock);
      chk("f0_count", int'(bus.remaining_sample_count), 1);
      chk("f0_out0", bus.sample_out_0, 2048);
      chk("f0_wvalid", int'(bus.window_valid), 0);
      chk("f0_ready", int'(bus.in_ready), 1);

      // Filter 1
      do_restart();
      push(3200, 0);
      push(0, 1);
      chk("f1_out0", bus.sample_out_0, 1600);
      chk("f1_out1", bus.sample_out_1, 1500);

      // Filter 2
      do_restart();
      push(1000, 0);
      push(2000, 0);
      push(0, 2);
      chk("f2_out2", bus.sample_out_2, 1437);
      chk("f2_count", int'(bus.remaining_sample_count), 3);
      chk("f2_wvalid", int'(bus.window_valid), 1);

      // Clamp and 15-bit wrap through filter 3
      do_restart();
      push(-32000, 0);
      push(32000, 0);
      push(32767, 3);
      chk("clip_out0", bus.sample_out_0, -16000);
      chk("clip_out1", bus.sample_out_1, 16000);
      chk("clip_out2", bus.sample_out_2, -1);

      // Full buffer and consume
      do_restart();
      for (int k = 0; k < DEPTH; k++)
         push((k + 1) * 200, 0);
      chk("full_count", int'(bus.remaining_sample_count), 8);
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sd1234;
      bus.in_filter = 2'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("full_ready", int'(bus.in_ready), 0);
         chk("full_hold_count", int'(bus.remaining_sample_count), 8);
      end
      bus.do_consume = 1'b1;
      @(negedge clock);
      bus.do_consume = 1'b0;
      bus.in_valid   = 1'b0;
      chk("cons_ready", int'(bus.in_ready), 1);
      chk("cons_count", int'(bus.remaining_sample_count), 7);
      chk("cons_out0", bus.sample_out_0, 200);

      // Write and consume in the same cycle
      do_restart();
      push(20, 0);
      push(40, 0);
      push(60, 0);
      chk("sim_pre_count", int'(bus.remaining_sample_count), 3);
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sd80;
      bus.in_filter = 2'd0;
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      @(negedge clock);
      bus.do_consume = 1'b1;
      @(negedge clock);
      bus.do_consume = 1'b0;
      chk("sim_count", int'(bus.remaining_sample_count), 3);
      chk("sim_out0", bus.sample_out_0, 20);
      chk("sim_out1", bus.sample_out_1, 30);
      chk("sim_out2", bus.sample_out_2, 40);

      // Drain, then consume while empty
      @(negedge clock);
      bus.do_consume = 1'b1;
      repeat (3) @(negedge clock);
      bus.do_consume = 1'b0;
      chk("drain_count", int'(bus.remaining_sample_count), 0);
      bus.do_consume = 1'b1;
      @(negedge clock);
      bus.do_consume = 1'b0;
      chk("empty_cons_count", int'(bus.remaining_sample_count), 0);
      push(100, 0);
      chk("empty_cons_out0", bus.sample_out_0, 50);
      chk("empty_cons_count1", int'(bus.remaining_sample_count), 1);

      // Restart while a sample is in CALC
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sd4000;
      bus.in_filter = 2'd0;
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.restart  = 1'b1;
      #1 chk("rs_ready", int'(bus.in_ready), 0);
      @(negedge clock);
      bus.restart = 1'b0;
      chk("rs_count", int'(bus.remaining_sample_count), 0);
      repeat (3) @(negedge clock);
      chk("rs_dropped_count", int'(bus.remaining_sample_count), 0);
      chk("rs_dropped_out0", bus.sample_out_0, 0);
      push(400, 1);
      chk("rs_hist_out0", bus.sample_out_0, 200);
      chk("rs_hist_count", int'(bus.remaining_sample_count), 1);

      // Asynchronous reset while a sample is in WRITE
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sd600;
      bus.in_filter = 2'd0;
      @(posedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("ar_count", int'(bus.remaining_sample_count), 0);
      chk("ar_out0", bus.sample_out_0, 0);
      chk("ar_wvalid", int'(bus.window_valid), 0);
      chk("ar_ready", int'(bus.in_ready), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("ar_after_count", int'(bus.remaining_sample_count), 0);
      chk("ar_after_out0", bus.sample_out_0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
